// File: rtl/icache_direct_mapped.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and
// the memory controller fetch port. Hits answer next cycle; misses go to memory.
module icache_direct_mapped #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rob_rollback_in,
  input  logic                  fet_request_in,
  input  logic [ADDR_WIDTH-1:0] fet_address_in,
  output logic                  fet_busy_out,
  output logic                  fet_ready_out,
  output logic [31:0]           fet_instruction_out,
  output logic                  mc_request_out,
  output logic [ADDR_WIDTH-1:0] mc_address_out,
  input  logic                  mc_ready_in,
  input  logic [31:0]           mc_instruction_in
);

  // state | meaning
  // IDLE  | accepting fetch requests; hits served from the line array
  // WAIT  | miss issued; waiting for the memory controller ready pulse
  typedef enum logic {IDLE, WAIT} state_t;

  localparam int LINES     = 1 << INDEX_BITS;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_BITS - 2;

  state_t state;

  logic [LINES-1:0]     valid_mem;
  logic [TAG_WIDTH-1:0] tag_mem  [LINES];
  logic [31:0]          data_mem [LINES];

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic [INDEX_BITS-1:0] miss_index;
  logic [TAG_WIDTH-1:0]  miss_tag;
  logic                  hit;
  logic                  fill;

  assign req_index  = fet_address_in[INDEX_BITS+1:2];
  assign req_tag    = fet_address_in[ADDR_WIDTH-1:INDEX_BITS+2];
  // mc_address_out doubles as the latched miss address; it holds until the next miss
  assign miss_index = mc_address_out[INDEX_BITS+1:2];
  assign miss_tag   = mc_address_out[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit        = valid_mem[req_index] && (tag_mem[req_index] == req_tag);
  assign fill       = (state == WAIT) && mc_ready_in && !rob_rollback_in;

  assign fet_busy_out = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      valid_mem           <= '0;
      fet_ready_out       <= 1'b0;
      fet_instruction_out <= '0;
      mc_request_out      <= 1'b0;
      mc_address_out      <= '0;
    end else begin
      fet_ready_out  <= 1'b0;
      mc_request_out <= 1'b0;
      if (rob_rollback_in) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (fet_request_in) begin
              if (hit) begin
                fet_ready_out       <= 1'b1;
                fet_instruction_out <= data_mem[req_index];
              end else begin
                mc_request_out <= 1'b1;
                mc_address_out <= fet_address_in;
                state          <= WAIT;
              end
            end
          end
          WAIT: begin
            if (mc_ready_in) begin
              valid_mem[miss_index] <= 1'b1;
              fet_ready_out         <= 1'b1;
              fet_instruction_out   <= mc_instruction_in;
              state                 <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      tag_mem[miss_index]  <= miss_tag;
      data_mem[miss_index] <= mc_instruction_in;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: miss, hit, eviction, rollback cases.
module tb_icache_direct_mapped;

  logic        clk = 1'b0;
  logic        rst;
  logic        rob_rollback_in;
  logic        fet_request_in;
  logic [31:0] fet_address_in;
  logic        fet_busy_out;
  logic        fet_ready_out;
  logic [31:0] fet_instruction_out;
  logic        mc_request_out;
  logic [31:0] mc_address_out;
  logic        mc_ready_in;
  logic [31:0] mc_instruction_in;

  int n_cmp  = 0;
  int n_fail = 0;

  icache_direct_mapped #(.INDEX_BITS(6), .ADDR_WIDTH(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .rob_rollback_in    (rob_rollback_in),
    .fet_request_in     (fet_request_in),
    .fet_address_in     (fet_address_in),
    .fet_busy_out       (fet_busy_out),
    .fet_ready_out      (fet_ready_out),
    .fet_instruction_out(fet_instruction_out),
    .mc_request_out     (mc_request_out),
    .mc_address_out     (mc_address_out),
    .mc_ready_in        (mc_ready_in),
    .mc_instruction_in  (mc_instruction_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // One-cycle fetch request; returns the registered outputs seen one cycle later.
  task automatic issue(input logic [31:0] addr, output logic rdy, output logic mreq);
    @(negedge clk);
    fet_request_in = 1'b1;
    fet_address_in = addr;
    @(negedge clk);
    fet_request_in = 1'b0;
    rdy  = fet_ready_out;
    mreq = mc_request_out;
  endtask

  task automatic mc_respond(input logic [31:0] data, output logic rdy);
    @(negedge clk);
    mc_ready_in       = 1'b1;
    mc_instruction_in = data;
    @(negedge clk);
    mc_ready_in = 1'b0;
    rdy = fet_ready_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rob_rollback_in = 1'b0;
    fet_request_in = 1'b0;
    fet_address_in = '0;
    mc_ready_in = 1'b0;
    mc_instruction_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({fet_ready_out, mc_request_out, fet_busy_out} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000", {fet_ready_out, mc_request_out, fet_busy_out});
    end
    n_cmp++;
    if (fet_instruction_out !== 32'h0 || mc_address_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: instr %h addr %h required 0/0", fet_instruction_out, mc_address_out);
    end
  endtask

  task automatic test_cold_miss();
    logic rdy, mreq;
    issue(32'h0, rdy, mreq);
    n_cmp++;
    if (mreq !== 1'b1 || rdy !== 1'b0 || mc_address_out !== 32'h0 || fet_busy_out !== 1'b1) begin
      n_fail++;
      $display("FAIL cold_miss_req: mreq %b rdy %b addr %h busy %b required 1 0 0 1", mreq, rdy, mc_address_out, fet_busy_out);
    end
    @(negedge clk);
    n_cmp++;
    if (mc_request_out !== 1'b0 || fet_busy_out !== 1'b1) begin
      n_fail++;
      $display("FAIL cold_miss_pulse: mreq %b busy %b required 0 1", mc_request_out, fet_busy_out);
    end
    mc_respond(32'h00000013, rdy);
    n_cmp++;
    if (rdy !== 1'b1 || fet_instruction_out !== 32'h00000013 || fet_busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL cold_miss_fill: rdy %b instr %h busy %b required 1 00000013 0", rdy, fet_instruction_out, fet_busy_out);
    end
    @(negedge clk);
    n_cmp++;
    if (fet_ready_out !== 1'b0 || fet_instruction_out !== 32'h00000013) begin
      n_fail++;
      $display("FAIL cold_miss_hold: rdy %b instr %h required 0 00000013", fet_ready_out, fet_instruction_out);
    end
  endtask

  task automatic test_hit();
    logic rdy, mreq;
    issue(32'h0, rdy, mreq);
    n_cmp++;
    if (rdy !== 1'b1 || mreq !== 1'b0 || fet_instruction_out !== 32'h00000013 || fet_busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL hit: rdy %b mreq %b instr %h busy %b required 1 0 00000013 0", rdy, mreq, fet_instruction_out, fet_busy_out);
    end
  endtask

  task automatic test_conflict_eviction();
    logic rdy, mreq;
    issue(32'h100, rdy, mreq);
    n_cmp++;
    if (mreq !== 1'b1 || mc_address_out !== 32'h100) begin
      n_fail++;
      $display("FAIL evict_miss: mreq %b addr %h required 1 00000100", mreq, mc_address_out);
    end
    mc_respond(32'hDEADBEEF, rdy);
    n_cmp++;
    if (rdy !== 1'b1 || fet_instruction_out !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL evict_fill: rdy %b instr %h required 1 deadbeef", rdy, fet_instruction_out);
    end
    issue(32'h100, rdy, mreq);
    n_cmp++;
    if (rdy !== 1'b1 || mreq !== 1'b0 || fet_instruction_out !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL evict_hit_new: rdy %b mreq %b instr %h required 1 0 deadbeef", rdy, mreq, fet_instruction_out);
    end
    issue(32'h0, rdy, mreq);
    n_cmp++;
    if (mreq !== 1'b1 || rdy !== 1'b0 || mc_address_out !== 32'h0) begin
      n_fail++;
      $display("FAIL evict_old_miss: mreq %b rdy %b addr %h required 1 0 0", mreq, rdy, mc_address_out);
    end
    mc_respond(32'h00000013, rdy);
    n_cmp++;
    if (rdy !== 1'b1 || fet_instruction_out !== 32'h00000013) begin
      n_fail++;
      $display("FAIL evict_refill: rdy %b instr %h required 1 00000013", rdy, fet_instruction_out);
    end
  endtask

  task automatic test_rollback_mid_miss();
    logic rdy, mreq;
    issue(32'h40, rdy, mreq);
    n_cmp++;
    if (mreq !== 1'b1 || mc_address_out !== 32'h40) begin
      n_fail++;
      $display("FAIL rb_mid_req: mreq %b addr %h required 1 00000040", mreq, mc_address_out);
    end
    repeat (2) @(negedge clk);
    rob_rollback_in = 1'b1;
    @(negedge clk);
    rob_rollback_in = 1'b0;
    n_cmp++;
    if (fet_ready_out !== 1'b0 || mc_request_out !== 1'b0 || fet_busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rb_mid_abort: rdy %b mreq %b busy %b required 0 0 0", fet_ready_out, mc_request_out, fet_busy_out);
    end
    issue(32'h40, rdy, mreq);
    n_cmp++;
    if (mreq !== 1'b1 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rb_mid_remiss: mreq %b rdy %b required 1 0", mreq, rdy);
    end
    mc_respond(32'hA5A5A5A5, rdy);
    n_cmp++;
    if (rdy !== 1'b1 || fet_instruction_out !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL rb_mid_fill: rdy %b instr %h required 1 a5a5a5a5", rdy, fet_instruction_out);
    end
  endtask

  task automatic test_rollback_with_ready();
    logic rdy, mreq;
    issue(32'h80, rdy, mreq);
    n_cmp++;
    if (mreq !== 1'b1 || mc_address_out !== 32'h80) begin
      n_fail++;
      $display("FAIL rb_rdy_req: mreq %b addr %h required 1 00000080", mreq, mc_address_out);
    end
    @(negedge clk);
    mc_ready_in = 1'b1;
    mc_instruction_in = 32'h12345678;
    rob_rollback_in = 1'b1;
    @(negedge clk);
    mc_ready_in = 1'b0;
    rob_rollback_in = 1'b0;
    n_cmp++;
    if (fet_ready_out !== 1'b0 || fet_busy_out !== 1'b0 || fet_instruction_out === 32'h12345678) begin
      n_fail++;
      $display("FAIL rb_rdy_drop: rdy %b busy %b instr %h required 0 0 not 12345678", fet_ready_out, fet_busy_out, fet_instruction_out);
    end
    issue(32'h80, rdy, mreq);
    n_cmp++;
    if (mreq !== 1'b1 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rb_rdy_nofill: mreq %b rdy %b required 1 0", mreq, rdy);
    end
    mc_respond(32'h00000011, rdy);
    n_cmp++;
    if (rdy !== 1'b1 || fet_instruction_out !== 32'h00000011) begin
      n_fail++;
      $display("FAIL rb_rdy_fill: rdy %b instr %h required 1 00000011", rdy, fet_instruction_out);
    end
  endtask

  task automatic test_rollback_idle_request();
    logic rdy, mreq;
    logic [31:0] addrs [2];
    addrs[0] = 32'h0;
    addrs[1] = 32'hC0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      fet_request_in = 1'b1;
      fet_address_in = addrs[i];
      rob_rollback_in = 1'b1;
      @(negedge clk);
      fet_request_in = 1'b0;
      rob_rollback_in = 1'b0;
      n_cmp++;
      if (fet_ready_out !== 1'b0 || mc_request_out !== 1'b0 || fet_busy_out !== 1'b0) begin
        n_fail++;
        $display("FAIL rb_idle_drop[%0d]: rdy %b mreq %b busy %b required 0 0 0", i, fet_ready_out, mc_request_out, fet_busy_out);
      end
    end
    issue(32'h0, rdy, mreq);
    n_cmp++;
    if (rdy !== 1'b1 || mreq !== 1'b0 || fet_instruction_out !== 32'h00000013) begin
      n_fail++;
      $display("FAIL rb_idle_hit: rdy %b mreq %b instr %h required 1 0 00000013", rdy, mreq, fet_instruction_out);
    end
  endtask

  task automatic test_ignored_inputs();
    logic rdy, mreq;
    mc_respond(32'hBAD0BAD0, rdy);
    n_cmp++;
    if (rdy !== 1'b0 || fet_busy_out !== 1'b0 || fet_instruction_out !== 32'h00000013) begin
      n_fail++;
      $display("FAIL idle_mc_ready: rdy %b busy %b instr %h required 0 0 00000013", rdy, fet_busy_out, fet_instruction_out);
    end
    issue(32'h207, rdy, mreq);
    n_cmp++;
    if (mreq !== 1'b1 || mc_address_out !== 32'h207) begin
      n_fail++;
      $display("FAIL wait_miss_addr: mreq %b addr %h required 1 00000207", mreq, mc_address_out);
    end
    issue(32'h0, rdy, mreq);
    n_cmp++;
    if (rdy !== 1'b0 || mreq !== 1'b0 || fet_busy_out !== 1'b1 || mc_address_out !== 32'h207) begin
      n_fail++;
      $display("FAIL wait_req_ignored: rdy %b mreq %b busy %b addr %h required 0 0 1 00000207", rdy, mreq, fet_busy_out, mc_address_out);
    end
    mc_respond(32'h00000077, rdy);
    n_cmp++;
    if (rdy !== 1'b1 || fet_instruction_out !== 32'h00000077) begin
      n_fail++;
      $display("FAIL wait_fill: rdy %b instr %h required 1 00000077", rdy, fet_instruction_out);
    end
    issue(32'h204, rdy, mreq);
    n_cmp++;
    if (rdy !== 1'b1 || mreq !== 1'b0 || fet_instruction_out !== 32'h00000077) begin
      n_fail++;
      $display("FAIL wait_fill_hit: rdy %b mreq %b instr %h required 1 0 00000077", rdy, mreq, fet_instruction_out);
    end
    issue(32'h0, rdy, mreq);
    n_cmp++;
    if (rdy !== 1'b1 || fet_instruction_out !== 32'h00000013) begin
      n_fail++;
      $display("FAIL other_line_kept: rdy %b instr %h required 1 00000013", rdy, fet_instruction_out);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict_eviction();
    test_rollback_mid_miss();
    test_rollback_with_ready();
    test_rollback_idle_request();
    test_ignored_inputs();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
